// File: rtl/allele_pkg.sv
// -----------------------------------------------------------------------------
// allele_pkg
// Shared definitions for the text-driven genetics front end:
//   - ASCII constants used by the line parser
//   - FSM state encoding of the allele pair collector
//   - character class encoding produced by allele_char_decode
// -----------------------------------------------------------------------------
package allele_pkg;

    localparam logic [7:0] CHR_A   = 8'h41;  // 'A'
    localparam logic [7:0] CHR_B   = 8'h42;  // 'B'
    localparam logic [7:0] CHR_O   = 8'h4F;  // 'O'
    localparam logic [7:0] CHR_SP  = 8'h20;  // ' '
    localparam logic [7:0] CHR_CR  = 8'h0D;  // carriage return
    localparam logic [7:0] CHR_LF  = 8'h0A;  // line feed
    localparam logic [7:0] CHR_UNK = 8'h3F;  // '?', shown before any pair is parsed

    // Lowercase counterparts of the allele letters.
    localparam logic [7:0] CHR_LA  = 8'h61;  // 'a'
    localparam logic [7:0] CHR_LB  = 8'h62;  // 'b'
    localparam logic [7:0] CHR_LO  = 8'h6F;  // 'o'

    typedef enum logic [2:0] {
        WAIT_M   = 3'd0,  // expecting the mother allele
        WAIT_F   = 3'd1,  // expecting the father allele
        WAIT_EOL = 3'd2,  // pair complete, expecting the line terminator
        SKIP     = 3'd3,  // rejected line, discarding up to the terminator
        HOLD     = 3'd4   // pair presented downstream, input stalled
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALLELE = 2'd0,
        CLS_SPACE  = 2'd1,
        CLS_EOL    = 2'd2,
        CLS_OTHER  = 2'd3
    } char_cls_t;

endpackage : allele_pkg

// File: rtl/allele_char_decode.sv
// -----------------------------------------------------------------------------
// allele_char_decode
// Purely combinational classifier for one ASCII character.
//
// Ports:
//   i_char   in   8  ASCII character
//   o_cls    out  2  character class (allele / space / eol / other)
//   o_allele out  8  uppercase allele letter when o_cls is CLS_ALLELE,
//                    CHR_UNK otherwise
// -----------------------------------------------------------------------------
module allele_char_decode
    import allele_pkg::*;
(
    input  logic [7:0] i_char,
    output char_cls_t  o_cls,
    output logic [7:0] o_allele
);

    always_comb begin
        o_cls    = CLS_OTHER;
        o_allele = CHR_UNK;
        case (i_char)
            CHR_A, CHR_LA: begin
                o_cls    = CLS_ALLELE;
                o_allele = CHR_A;
            end
            CHR_B, CHR_LB: begin
                o_cls    = CLS_ALLELE;
                o_allele = CHR_B;
            end
            CHR_O, CHR_LO: begin
                o_cls    = CLS_ALLELE;
                o_allele = CHR_O;
            end
            CHR_SP: begin
                o_cls = CLS_SPACE;
            end
            CHR_CR, CHR_LF: begin
                o_cls = CLS_EOL;
            end
            default: begin
                o_cls    = CLS_OTHER;
                o_allele = CHR_UNK;
            end
        endcase
    end

endmodule : allele_char_decode

// File: rtl/allele_pair_collector.sv
// -----------------------------------------------------------------------------
// allele_pair_collector
// Parses an ASCII stream of lines "<mother><father><EOL>" into a registered
// allele pair for the phenotype decoder. Malformed lines are dropped and
// counted; well-formed pairs are held until the downstream accepts them.
//
// Ports:
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous active-low reset
//   in_char     in   8      ASCII character from upstream
//   in_valid    in   1      in_char valid
//   in_ready    out  1      character accepted this cycle (low only in HOLD)
//   allelm      out  8      mother allele, uppercase ASCII
//   allelf      out  8      father allele, uppercase ASCII
//   out_valid   out  1      allelm/allelf hold a complete pair
//   out_ready   in   1      downstream consumes the pair
//   err_pulse   out  1      one-cycle pulse per rejected line
//   pair_count  out  CNT_W  pairs delivered, saturating
//   err_count   out  CNT_W  lines rejected, saturating
// -----------------------------------------------------------------------------
module allele_pair_collector
    import allele_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_char,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       allelm,
    output logic [7:0]       allelf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_pulse,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_allelm;
    logic [7:0]       r_allelf;
    logic             r_out_valid;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_pair_count;
    logic [CNT_W-1:0] r_err_count;

    char_cls_t        w_cls;
    logic [7:0]       w_allele;
    logic             w_in_ready;
    logic             w_acc;
    logic             w_store_m;
    logic             w_store_f;
    logic             w_err;
    logic             w_release;

    allele_char_decode u_decode (
        .i_char   (in_char),
        .o_cls    (w_cls),
        .o_allele (w_allele)
    );

    // Input is stalled only while a pair waits for the downstream.
    assign w_in_ready = (r_state != HOLD);
    assign w_acc      = in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_store_m   = 1'b0;
        w_store_f   = 1'b0;
        w_err       = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            WAIT_M: begin
                if (w_acc) begin
                    case (w_cls)
                        CLS_ALLELE: begin
                            w_store_m   = 1'b1;
                            w_state_nxt = WAIT_F;
                        end
                        CLS_OTHER: begin
                            w_err       = 1'b1;
                            w_state_nxt = SKIP;
                        end
                        // Spaces, blank lines and the LF of a CRLF pair.
                        default: w_state_nxt = WAIT_M;
                    endcase
                end
            end
            WAIT_F: begin
                if (w_acc) begin
                    case (w_cls)
                        CLS_ALLELE: begin
                            w_store_f   = 1'b1;
                            w_state_nxt = WAIT_EOL;
                        end
                        // The terminator already ended the short line, so
                        // there is nothing left to skip.
                        CLS_EOL: begin
                            w_err       = 1'b1;
                            w_state_nxt = WAIT_M;
                        end
                        CLS_OTHER: begin
                            w_err       = 1'b1;
                            w_state_nxt = SKIP;
                        end
                        default: w_state_nxt = WAIT_F;
                    endcase
                end
            end
            WAIT_EOL: begin
                if (w_acc) begin
                    case (w_cls)
                        CLS_EOL:   w_state_nxt = HOLD;
                        CLS_SPACE: w_state_nxt = WAIT_EOL;
                        // A third allele or any stray character.
                        default: begin
                            w_err       = 1'b1;
                            w_state_nxt = SKIP;
                        end
                    endcase
                end
            end
            SKIP: begin
                if (w_acc && (w_cls == CLS_EOL)) begin
                    w_state_nxt = WAIT_M;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = WAIT_M;
                end
            end
            default: w_state_nxt = WAIT_M;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_M;
            r_allelm     <= CHR_UNK;
            r_allelf     <= CHR_UNK;
            r_out_valid  <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_pair_count <= '0;
            r_err_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // out_valid mirrors HOLD as a register so it is glitch-free.
            r_out_valid <= (w_state_nxt == HOLD);
            r_err_pulse <= w_err;
            if (w_store_m) begin
                r_allelm <= w_allele;
            end
            if (w_store_f) begin
                r_allelf <= w_allele;
            end
            if (w_err) begin
                r_err_count <= sat_inc(r_err_count);
            end
            if (w_release) begin
                r_pair_count <= sat_inc(r_pair_count);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign allelm     = r_allelm;
    assign allelf     = r_allelf;
    assign out_valid  = r_out_valid;
    assign err_pulse  = r_err_pulse;
    assign pair_count = r_pair_count;
    assign err_count  = r_err_count;

endmodule : allele_pair_collector
